// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the ID stage and the hazard scoreboard.
// The pipeline side (master) drives issue/ID information and consumes the
// stall and tracking outputs; the scoreboard (slave) does the reverse.
interface hazard_scoreboard_if;
    // Instruction moving ID->EX at the coming edge
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_RegWrite;
    logic [1:0]  issue_kind;

    // Instruction currently in ID
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic        use_rs1_ID;
    logic        use_rs2_ID;
    logic [4:0]  rd_ID;
    logic        RegWrite_ID;
    logic        div_ID;
    logic        branch_ID;

    // Global pipeline / divider events
    logic        pipe_hold;
    logic        div_done;

    // Scoreboard results
    logic        stall_ID;
    logic [1:0]  stall_cause;
    logic        div_busy;
    logic [4:0]  div_rd;
    logic [31:0] pending_vec;

    modport master (
        output issue_valid, issue_rd, issue_RegWrite, issue_kind,
        output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
        output rd_ID, RegWrite_ID, div_ID, branch_ID,
        output pipe_hold, div_done,
        input  stall_ID, stall_cause, div_busy, div_rd, pending_vec
    );

    modport slave (
        input  issue_valid, issue_rd, issue_RegWrite, issue_kind,
        input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
        input  rd_ID, RegWrite_ID, div_ID, branch_ID,
        input  pipe_hold, div_done,
        output stall_ID, stall_cause, div_busy, div_rd, pending_vec
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks destinations of in-flight loads (2-cycle
// countdown per register) and the single outstanding divide, and raises the
// ID-stage stall whenever the forwarding network cannot cover a dependency.
module hazard_scoreboard (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [1:0] KIND_LOAD = 2'b01;
    localparam logic [1:0] KIND_DIV  = 2'b10;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_LOAD = 2'b01;
    localparam logic [1:0] CAUSE_DIV  = 2'b10;
    localparam logic [1:0] CAUSE_BUSY = 2'b11;

    // Entry 0 is never written, so it reads as zero for x0 sources
    logic [31:0][1:0] ld_cnt;
    logic             busy_q;
    logic [4:0]       div_rd_q;

    logic             issue_wr;
    logic [1:0]       cnt1;
    logic [1:0]       cnt2;
    logic             hit1;
    logic             hit2;
    logic             load_use;
    logic             div_dep;
    logic             div_struct;
    logic [1:0]       cause;
    logic [31:0]      pend;

    assign issue_wr = sb.issue_valid && sb.issue_RegWrite && (sb.issue_rd != '0);

    // Load countdowns: an issue to a register overrides its decrement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt <= '0;
        end else begin
            for (int unsigned r = 1; r < 32; r++) begin
                if (issue_wr && (sb.issue_rd == r[4:0])) begin
                    ld_cnt[r] <= (sb.issue_kind == KIND_LOAD) ? 2'd2 : 2'd0;
                end else if (!sb.pipe_hold && (ld_cnt[r] != '0)) begin
                    ld_cnt[r] <= ld_cnt[r] - 2'd1;
                end
            end
        end
    end

    // Outstanding divide: set on divide issue, cleared by the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= 1'b0;
            div_rd_q <= '0;
        end else if (issue_wr && (sb.issue_kind == KIND_DIV)) begin
            busy_q   <= 1'b1;
            div_rd_q <= sb.issue_rd;
        end else if (sb.div_done && busy_q) begin
            busy_q   <= 1'b0;
        end
    end

    // Stall conditions evaluated on current state and the instruction in ID
    always_comb begin
        cnt1 = ld_cnt[sb.rs1_ID];
        cnt2 = ld_cnt[sb.rs2_ID];
        hit1 = sb.use_rs1_ID && (sb.rs1_ID != '0);
        hit2 = sb.use_rs2_ID && (sb.rs2_ID != '0);

        load_use = (hit1 && ((cnt1 == 2'd2) || (sb.branch_ID && (cnt1 != '0)))) ||
                   (hit2 && ((cnt2 == 2'd2) || (sb.branch_ID && (cnt2 != '0))));

        div_dep = busy_q &&
                  ((hit1 && (sb.rs1_ID == div_rd_q)) ||
                   (hit2 && (sb.rs2_ID == div_rd_q)) ||
                   (sb.RegWrite_ID && (sb.rd_ID == div_rd_q) && (sb.rd_ID != '0)));

        div_struct = sb.div_ID && busy_q;

        if (div_struct) begin
            cause = CAUSE_BUSY;
        end else if (div_dep) begin
            cause = CAUSE_DIV;
        end else if (load_use) begin
            cause = CAUSE_LOAD;
        end else begin
            cause = CAUSE_NONE;
        end
    end

    // Per-register pending view: live load countdown or outstanding divide target
    always_comb begin
        pend = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            pend[r] = (ld_cnt[r] != '0) || (busy_q && (div_rd_q == r[4:0]));
        end
    end

    assign sb.stall_ID    = load_use || div_dep || div_struct;
    assign sb.stall_cause = cause;
    assign sb.div_busy    = busy_q;
    assign sb.div_rd      = div_rd_q;
    assign sb.pending_vec = pend;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. Each cycle the expected output
// vector is pushed to a queue as stimulus is driven, then popped and compared
// at the falling edge.
module tb_hazard_scoreboard;
    localparam logic [1:0] K_ALU  = 2'b00;
    localparam logic [1:0] K_LOAD = 2'b01;
    localparam logic [1:0] K_DIV  = 2'b10;

    typedef struct {
        string       name;
        logic [40:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sbq[$];

    hazard_scoreboard_if bus();

    hazard_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    logic [40:0] obs;
    assign obs = {bus.stall_ID, bus.stall_cause, bus.div_busy, bus.div_rd, bus.pending_vec};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal stimulus guards
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(bus.issue_valid && bus.issue_RegWrite && bus.div_busy &&
                      (bus.issue_rd == bus.div_rd) && (bus.issue_rd != 5'd0)))
                else $error("issue writes the outstanding divide destination");
            assert (!(bus.issue_valid && bus.pipe_hold))
                else $error("issue while pipe_hold is asserted");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pb(input int r);
        return 32'd1 << r;
    endfunction

    task automatic idle();
        bus.issue_valid    = 1'b0;
        bus.issue_rd       = 5'd0;
        bus.issue_RegWrite = 1'b0;
        bus.issue_kind     = K_ALU;
        bus.rs1_ID         = 5'd0;
        bus.rs2_ID         = 5'd0;
        bus.use_rs1_ID     = 1'b0;
        bus.use_rs2_ID     = 1'b0;
        bus.rd_ID          = 5'd0;
        bus.RegWrite_ID    = 1'b0;
        bus.div_ID         = 1'b0;
        bus.branch_ID      = 1'b0;
        bus.pipe_hold      = 1'b0;
        bus.div_done       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [1:0] kind, input logic rw);
        bus.issue_valid    = 1'b1;
        bus.issue_rd       = rd;
        bus.issue_kind     = kind;
        bus.issue_RegWrite = rw;
    endtask

    task automatic id_src(input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic br);
        bus.rs1_ID     = r1;
        bus.use_rs1_ID = u1;
        bus.rs2_ID     = r2;
        bus.use_rs2_ID = u2;
        bus.branch_ID  = br;
    endtask

    task automatic id_dst(input logic [4:0] rd, input logic rw, input logic dv);
        bus.rd_ID       = rd;
        bus.RegWrite_ID = rw;
        bus.div_ID      = dv;
    endtask

    task automatic push_exp(input string nm, input logic st, input logic [1:0] cs,
                            input logic bz, input logic [4:0] dr, input logic [31:0] pv);
        exp_t e;
        e.name = nm;
        e.val  = {st, cs, bz, dr, pv};
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        idle();
        id_src(5'd3, 1'b1, 5'd4, 1'b1, 1'b1);
        id_dst(5'd5, 1'b1, 1'b1);
        push_exp("reset", 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        e = sbq.pop_front();
        vectors++;
        if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        exp_t e;
        string nm;
        for (int c = 0; c < 4; c++) begin
            idle();
            nm = $sformatf("load_use[%0d]", c);
            case (c)
                0: begin
                    issue(5'd5, K_LOAD, 1'b1);
                    id_src(5'd1, 1'b1, 5'd2, 1'b1, 1'b0);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                1: begin
                    id_src(5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
                    push_exp(nm, 1'b1, 2'b01, 1'b0, 5'd0, pb(5));
                end
                2: begin
                    id_src(5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
                    issue(5'd10, K_ALU, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, pb(5));
                end
                default: push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_branch();
        exp_t e;
        string nm;
        for (int c = 0; c < 7; c++) begin
            idle();
            nm = $sformatf("load_branch[%0d]", c);
            case (c)
                0: begin
                    issue(5'd6, K_LOAD, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                1, 2: begin
                    id_src(5'd6, 1'b1, 5'd0, 1'b1, 1'b1);
                    push_exp(nm, 1'b1, 2'b01, 1'b0, 5'd0, pb(6));
                end
                3: begin
                    id_src(5'd6, 1'b1, 5'd0, 1'b1, 1'b1);
                    issue(5'd0, K_ALU, 1'b0);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                4: begin
                    issue(5'd7, K_ALU, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                5: begin
                    id_src(5'd7, 1'b1, 5'd0, 1'b0, 1'b1);
                    issue(5'd0, K_ALU, 1'b0);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                default: push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_shadow_hold();
        exp_t e;
        string nm;
        for (int c = 0; c < 10; c++) begin
            idle();
            nm = $sformatf("shadow_hold[%0d]", c);
            case (c)
                0: begin
                    issue(5'd7, K_LOAD, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                1: begin
                    id_src(5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
                    id_dst(5'd7, 1'b1, 1'b0);
                    issue(5'd7, K_ALU, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, pb(7));
                end
                2: begin
                    id_src(5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                3: begin
                    id_src(5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
                    issue(5'd8, K_LOAD, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                4, 5, 6: begin
                    id_src(5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
                    bus.pipe_hold = 1'b1;
                    push_exp(nm, 1'b1, 2'b01, 1'b0, 5'd0, pb(8));
                end
                7: begin
                    id_src(5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
                    push_exp(nm, 1'b1, 2'b01, 1'b0, 5'd0, pb(8));
                end
                8: begin
                    id_src(5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
                    issue(5'd11, K_ALU, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, pb(8));
                end
                default: push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0_unused();
        exp_t e;
        string nm;
        for (int c = 0; c < 6; c++) begin
            idle();
            nm = $sformatf("x0_unused[%0d]", c);
            case (c)
                0: begin
                    issue(5'd0, K_LOAD, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                1: begin
                    id_src(5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                2: begin
                    issue(5'd3, K_LOAD, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                3, 4: begin
                    id_src(5'd3, 1'b0, 5'd3, 1'b0, 1'b1);
                    id_dst(5'd3, 1'b1, 1'b0);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, pb(3));
                end
                default: push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_divide();
        exp_t e;
        string nm;
        for (int c = 0; c < 13; c++) begin
            idle();
            nm = $sformatf("divide[%0d]", c);
            case (c)
                0: begin
                    id_dst(5'd9, 1'b1, 1'b1);
                    issue(5'd9, K_DIV, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
                end
                1: begin
                    id_src(5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
                    push_exp(nm, 1'b1, 2'b10, 1'b1, 5'd9, pb(9));
                end
                2: begin
                    id_src(5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
                    id_dst(5'd12, 1'b1, 1'b1);
                    push_exp(nm, 1'b1, 2'b11, 1'b1, 5'd9, pb(9));
                end
                3: begin
                    id_dst(5'd9, 1'b1, 1'b0);
                    push_exp(nm, 1'b1, 2'b10, 1'b1, 5'd9, pb(9));
                end
                4: begin
                    id_dst(5'd13, 1'b1, 1'b1);
                    push_exp(nm, 1'b1, 2'b11, 1'b1, 5'd9, pb(9));
                end
                5, 6, 7: begin
                    id_src(5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
                    push_exp(nm, 1'b1, 2'b10, 1'b1, 5'd9, pb(9));
                end
                8: begin
                    id_src(5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
                    bus.div_done = 1'b1;
                    push_exp(nm, 1'b1, 2'b10, 1'b1, 5'd9, pb(9));
                end
                9: begin
                    id_src(5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
                    issue(5'd14, K_ALU, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd9, 32'd0);
                end
                10: begin
                    id_dst(5'd15, 1'b1, 1'b1);
                    issue(5'd15, K_DIV, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd9, 32'd0);
                end
                11: begin
                    bus.div_done = 1'b1;
                    push_exp(nm, 1'b0, 2'b00, 1'b1, 5'd15, pb(15));
                end
                default: push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd15, 32'd0);
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        string nm;
        for (int c = 0; c < 3; c++) begin
            idle();
            nm = $sformatf("async_setup[%0d]", c);
            case (c)
                0: begin
                    issue(5'd20, K_DIV, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b0, 5'd15, 32'd0);
                end
                1: begin
                    id_src(5'd1, 1'b1, 5'd0, 1'b0, 1'b0);
                    issue(5'd4, K_LOAD, 1'b1);
                    push_exp(nm, 1'b0, 2'b00, 1'b1, 5'd20, pb(20));
                end
                default: begin
                    id_src(5'd4, 1'b1, 5'd20, 1'b1, 1'b0);
                    push_exp(nm, 1'b1, 2'b10, 1'b1, 5'd20, pb(4) | pb(20));
                end
            endcase
            @(negedge clk);
            e = sbq.pop_front();
            vectors++;
            if (obs !== e.val) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
            end
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end

        // Reset mid-cycle with the dependent still in ID: outputs drop before the next edge
        #1 rst = 1'b1;
        push_exp("async_reset_immediate", 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
        #1;
        e = sbq.pop_front();
        vectors++;
        if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end

        push_exp("async_reset_held", 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        e = sbq.pop_front();
        vectors++;
        if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end
        #1 rst = 1'b0;

        @(posedge clk); #1;
        push_exp("async_reset_after", 1'b0, 2'b00, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        e = sbq.pop_front();
        vectors++;
        if (obs !== e.val) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", e.name, obs, e.val);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle();

        test_reset();
        test_load_use();
        test_load_branch();
        test_load_shadow_hold();
        test_x0_unused();
        test_divide();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Producer-side companion to the forwarding unit. It tracks in-flight destination registers whose values cannot yet be supplied by the EX/MEM/WB forwarding paths: loads still in EX/MEM, and the single out-of-pipe divider result. It raises the ID-stage stall whenever forwarding alone cannot cover a dependency. It sits beside the ID/EX pipeline register and drives the IF/ID hold and the ID/EX bubble insertion.

## Interface
- No parameters; register file is fixed at 32 entries, x0 is never tracked.

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- issue_valid  in  1  instruction moves ID→EX at this edge; 0 when stall_ID=1 or pipe_hold=1
- issue_rd  in  5  its destination register
- issue_RegWrite  in  1  its write enable
- issue_kind  in  2  00 ALU/other, 01 load, 10 divide, 11 reserved (treated as 00)
- rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID
- use_rs1_ID, use_rs2_ID  in  1 each  source actually read
- rd_ID  in  5, RegWrite_ID  in  1  destination of the instruction in ID (WAW check)
- div_ID  in  1  instruction in ID is a divide
- branch_ID  in  1  instruction in ID resolves in ID (branch/JALR), so it needs operands in ID
- pipe_hold  in  1  global freeze (memory wait); countdowns do not advance
- div_done  in  1  one-cycle pulse, divider result written to the register file at this edge
- stall_ID  out  1  hold IF/ID, bubble into ID/EX
- stall_cause  out  2  00 none, 01 load-use, 10 divide RAW/WAW, 11 divider busy
- div_busy  out  1  divide outstanding
- div_rd  out  5  destination of the outstanding divide
- pending_vec  out  32  bit r set if ld_cnt[r]≠0 or r is the outstanding divide rd

## Operation
- State per register r (1..31): ld_cnt[r], 2 bits. Divider state: div_busy and div_rd.
- Issue, at an edge with issue_valid && issue_RegWrite && issue_rd≠0:
  - load: ld_cnt[rd]←2, overwriting any older value.
  - ALU/other/divide: ld_cnt[rd]←0. The younger write wins, and forwarding priority already selects it.
  - divide: div_busy←1 and div_rd←issue_rd.
- Countdown: at every edge with !pipe_hold, each nonzero ld_cnt decrements. An issue to the same register in the same cycle takes precedence over the decrement.
- div_done edge: div_busy←0. div_done with div_busy=0 is ignored.
- A source s counts as "hit" when its use bit is set and s≠0. The following conditions are evaluated combinationally on the current state:
  - load-use: some hit s has ld_cnt[s]==2, or branch_ID and ld_cnt[s]≥1.
  - div RAW/WAW: div_busy and (a hit s==div_rd, or RegWrite_ID && rd_ID==div_rd && rd_ID≠0).
  - div structural: div_ID && div_busy.
- stall_ID is the OR of the three conditions.
- stall_cause priority: 11 > 10 > 01.
- On the div_done cycle, div_busy is still 1, so dependents and a new divide stall that cycle. They proceed the next cycle by reading the register file.
- An issue that writes div_rd while div_busy=1 is illegal. The bench asserts it never occurs.
- issue_valid with pipe_hold=1 is illegal.

## Timing
- Reset (async): ld_cnt all 0, div_busy 0, div_rd 0. Every output is therefore 0: stall_ID 0, stall_cause 00, div_busy 0, div_rd 0, pending_vec 0.
- All outputs are combinational from registered state and the ID inputs. They are valid in the same cycle, with no added latency.
- Load issued at edge t, no hold:
  - non-branch dependent stalls exactly 1 cycle;
  - branch dependent stalls exactly 2 cycles;
  - ALU-produced operands never stall.
- Each pipe_hold cycle extends these windows by one cycle.
- Divide issued at edge t: dependents stall from t+1 through the div_done cycle inclusive.
- Reset asserted mid-operation clears all tracking immediately. A stall in progress drops in the same cycle.

## Test plan
- Load-use: ld x5 issued, next ID add uses x5 → stall_ID=1, cause 01, for 1 cycle. Then 0, pending_vec[5] clears after 2 edges.
- Load→branch: ld x6 then beq x6,x0 → stall_ID=1 for 2 cycles, cause 01. ALU producer then beq → no stall.
- Load shadowed: ld x7, then add x7 issued next → ld_cnt[7]=0, a consumer of x7 does not stall. pipe_hold=1 for 3 cycles after a load → stall held 4 cycles total.
- Divide: div x9 issued, div_done 8 cycles later → a consumer of x9 stalls cause 10 through the done cycle. A second div in ID stalls cause 11. Writer of x9 in ID stalls cause 10.
- x0/unused: ld x0 then a use of x0, and ld x3 then an instruction with use_rs1_ID=0 reading x3 → never stall.
- Async reset with div_busy=1 and ld_cnt[4]=2 → all outputs 0 immediately, before the next clk edge.
